w3d_dram_rd_arbiter: RTL
========================

Name: w3d_dram_rd_arbiter

Overview:
- Shares the single DRAM AXI read path (AR and R channels) among N read requesters: host ibus, host dbus and gfx fetch.
- Arbitration is round-robin. The requester index is prefixed onto the downstream ARID.
- R beats are routed back to their requester by decoding the RID prefix.
- Sits inside w3d_interconnect, between the requester read channels and the DRAM master port. Write channels bypass this block.

Parameters:
- N, 3, number of requesters (2..8)
- SRC_W, $clog2(N), ID prefix width (derived, not overridable)
- ID_W, 8, downstream AXI ID width
- MAX_OUTST, 4, maximum outstanding AR bursts per requester (1..15)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- req_arvalid  in  N  per-requester AR valid
- req_arready  out  N  per-requester AR ready
- req_arid  in  N*(ID_W-SRC_W)  per-requester ARID
- req_araddr  in  N*32  per-requester address
- req_arlen  in  N*8  per-requester burst length
- req_arsize  in  N*3  per-requester beat size
- req_arburst  in  N*2  per-requester burst type
- req_rvalid  out  N  per-requester R valid
- req_rready  in  N  per-requester R ready
- req_rid  out  ID_W-SRC_W  RID with prefix stripped (shared)
- req_rdata  out  32  shared R data
- req_rresp  out  2  shared R response
- req_rlast  out  1  shared R last
- dram_arvalid/arready/arid[ID_W]/araddr[32]/arlen[8]/arsize[3]/arburst[2]  out/in/out...  downstream AR channel
- dram_rvalid/rready/rid[ID_W]/rdata[32]/rresp[2]/rlast  in/out/in/in/in/in  downstream R channel

Behaviour:
- Clock is clk. Reset is rst: one clock, asynchronous, active-high.
- Reset values:
  - state=IDLE, rr_ptr=0, all outst counters=0.
  - dram_arvalid=0, req_arready=0, and all AR payload registers=0.
- Arbiter FSM, two states:
  - IDLE: eligible[i] = req_arvalid[i] && outst[i] != MAX_OUTST. If any requester is eligible, grant the first eligible index at or after rr_ptr (wrapping at N-1→0). In the same cycle:
    - pulse req_arready[grant] = 1;
    - register the payload;
    - set dram_arid = {grant[SRC_W-1:0], req_arid[grant]};
    - go to ISSUE.
    The registered AR is therefore visible on dram_ar* one cycle after the upstream handshake.
  - ISSUE: dram_arvalid=1 and payload held stable. On dram_arready:
    - outst[grant] += 1;
    - rr_ptr = grant+1 mod N;
    - go to IDLE.
    There is no back-to-back issue, so AR throughput is one burst per 2 cycles minimum.
- req_arready is 0 in every state other than the IDLE grant cycle.
- R routing is combinational, zero latency:
  - src = dram_rid[ID_W-1 -: SRC_W]
  - req_rvalid[src] = dram_rvalid; all other bits of req_rvalid = 0
  - dram_rready = req_rready[src]
  - data, resp, last and stripped id are broadcast to all requesters.
- An RID prefix >= N is an error: assert dram_rready=1, drop the beat, req_rvalid all 0. A simulation assertion fires on this case.
- Counter rules:
  - outst[src] -= 1 on a dram R handshake with rlast.
  - If the increment (ISSUE accept) and the decrement hit the same counter in the same cycle, the net change is 0.
  - A counter never wraps: reaching MAX_OUTST blocks eligibility; a decrement at 0 is an assertion error.
- rr_ptr advances only on an accepted grant. The requester that just won has lowest priority next round.
- Reset mid-burst: all state is cleared. Bursts in flight downstream are lost; the upstream srst domain must reset the requesters together with this block.

Decomposition:
- w3d_pkg holds:
  - w3d_dram_id_t (ID_W bits);
  - the src_id_t typedef;
  - arb_state_t enum {IDLE, ISSUE};
  - the DRAM_ID_W constant.
- One sub-module, w3d_rr_pick: N-bit request vector plus pointer in, one-hot grant and index out (purely combinational). It is reused later for the write arbiter.

Test Plan:
- Single request: req 1 arvalid with araddr=0x1000, arlen=3, arid=0x05 → arready[1] in cycle 0; dram_arvalid in cycle 1 with arid=0x45 (SRC_W=2); four R beats with rid=0x45 → req_rvalid=3'b010 with rid=0x05, rlast on beat 4.
- Contention: all three requesters valid continuously, dram_arready=1 → grant order 0,1,2,0,1,2; each dram AR spaced 2 cycles apart.
- Outstanding cap: requester 0 issues 4 ARs with no R returned → fifth is not granted while requesters 1 and 2 are still served; one rlast to requester 0 → its grant resumes.
- R backpressure: req_rready[2]=0 during a beat with rid prefix 2 → dram_rready=0 and the beat is held; req_rready=1 → beat passes with data unchanged.
- Simultaneous inc/dec: ISSUE accept and rlast for the same requester in one cycle, starting from outst=2 → outst remains 2.
- Async reset: assert rst during ISSUE → dram_arvalid drops to 0 without waiting for a clock; counters are 0 after release and the first grant goes to requester 0.

Source files
------------

// File: rtl/w3d_pkg.sv
// w3d_pkg: shared types and constants for the w3d DRAM read arbiter
package w3d_pkg;

    localparam int DRAM_ID_W = 8;
    localparam int SRC_MAX_W = 4;

    typedef logic [DRAM_ID_W-1:0] w3d_dram_id_t;
    typedef logic [SRC_MAX_W-1:0] src_id_t;
    typedef enum logic {IDLE, ISSUE} arb_state_t;

endpackage

// File: rtl/w3d_rr_pick.sv
// w3d_rr_pick: combinational round-robin picker, first request at or after ptr_i
module w3d_rr_pick #(
    parameter int N = 3,
    localparam int SRC_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [SRC_W-1:0] ptr_i,
    output logic [N-1:0]     gnt_o,
    output logic [SRC_W-1:0] idx_o,
    output logic             any_o
);

    // Walk offsets from farthest to nearest so the nearest request to ptr_i wins
    always_comb begin
        int j;
        j = 0;
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            j = (int'(ptr_i) + k) % N;
            if (req_i[j]) begin
                gnt_o    = '0;
                gnt_o[j] = 1'b1;
                idx_o    = SRC_W'(j);
                any_o    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/w3d_dram_rd_arbiter.sv
// w3d_dram_rd_arbiter: round-robin sharing of the DRAM AXI read path among N requesters
module w3d_dram_rd_arbiter
    import w3d_pkg::*;
#(
    parameter int N = 3,
    parameter int ID_W = DRAM_ID_W,
    parameter int MAX_OUTST = 4,
    localparam int SRC_W = $clog2(N),
    localparam int IW = ID_W - SRC_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req_arvalid,
    output logic [N-1:0]    req_arready,
    input  logic [N*IW-1:0] req_arid,
    input  logic [N*32-1:0] req_araddr,
    input  logic [N*8-1:0]  req_arlen,
    input  logic [N*3-1:0]  req_arsize,
    input  logic [N*2-1:0]  req_arburst,
    output logic [N-1:0]    req_rvalid,
    input  logic [N-1:0]    req_rready,
    output logic [IW-1:0]   req_rid,
    output logic [31:0]     req_rdata,
    output logic [1:0]      req_rresp,
    output logic            req_rlast,
    output logic            dram_arvalid,
    input  logic            dram_arready,
    output logic [ID_W-1:0] dram_arid,
    output logic [31:0]     dram_araddr,
    output logic [7:0]      dram_arlen,
    output logic [2:0]      dram_arsize,
    output logic [1:0]      dram_arburst,
    input  logic            dram_rvalid,
    output logic            dram_rready,
    input  logic [ID_W-1:0] dram_rid,
    input  logic [31:0]     dram_rdata,
    input  logic [1:0]      dram_rresp,
    input  logic            dram_rlast
);

    localparam int CW = 4;

    arb_state_t       state_q, state_d;
    logic [SRC_W-1:0] rr_q, rr_d, gnt_q, gnt_d;
    logic [ID_W-1:0]  arid_q, arid_d;
    logic [31:0]      araddr_q, araddr_d;
    logic [7:0]       arlen_q, arlen_d;
    logic [2:0]       arsize_q, arsize_d;
    logic [1:0]       arburst_q, arburst_d;
    logic [CW-1:0]    outst_q [N];
    logic [CW-1:0]    outst_d [N];
    logic [N-1:0]     elig, pick_gnt;
    logic [SRC_W-1:0] pick_idx, rsrc;
    logic             pick_any, rbad, rdone, ar_acc;

    // A requester competes only while it has headroom for another burst
    always_comb begin
        elig = '0;
        for (int i = 0; i < N; i++)
            elig[i] = req_arvalid[i] && (outst_q[i] != CW'(MAX_OUTST));
    end

    w3d_rr_pick #(.N(N)) u_pick (
        .req_i (elig),
        .ptr_i (rr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    // Arbiter: grant and capture in IDLE, hold the AR until DRAM accepts in ISSUE
    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        gnt_d       = gnt_q;
        arid_d      = arid_q;
        araddr_d    = araddr_q;
        arlen_d     = arlen_q;
        arsize_d    = arsize_q;
        arburst_d   = arburst_q;
        req_arready = '0;
        if (state_q == IDLE) begin
            if (pick_any && !rst) begin
                req_arready = pick_gnt;
                gnt_d       = pick_idx;
                arid_d      = {pick_idx, req_arid[pick_idx*IW +: IW]};
                araddr_d    = req_araddr[pick_idx*32 +: 32];
                arlen_d     = req_arlen[pick_idx*8 +: 8];
                arsize_d    = req_arsize[pick_idx*3 +: 3];
                arburst_d   = req_arburst[pick_idx*2 +: 2];
                state_d     = ISSUE;
            end
        end else if (dram_arready) begin
            rr_d    = (gnt_q == SRC_W'(N - 1)) ? '0 : gnt_q + 1'b1;
            state_d = IDLE;
        end
    end

    assign dram_arvalid = (state_q == ISSUE);
    assign ar_acc       = dram_arvalid && dram_arready;
    assign dram_arid    = arid_q;
    assign dram_araddr  = araddr_q;
    assign dram_arlen   = arlen_q;
    assign dram_arsize  = arsize_q;
    assign dram_arburst = arburst_q;

    // Beats with an unknown prefix are swallowed so the DRAM side never stalls on them
    assign rsrc        = dram_rid[ID_W-1 -: SRC_W];
    assign rbad        = src_id_t'(rsrc) >= src_id_t'(N);
    assign req_rvalid  = (dram_rvalid && !rbad) ? ({{(N-1){1'b0}}, 1'b1} << rsrc) : '0;
    assign dram_rready = rbad || req_rready[rsrc];
    assign rdone       = dram_rvalid && dram_rready && dram_rlast && !rbad;
    assign req_rid     = dram_rid[IW-1:0];
    assign req_rdata   = dram_rdata;
    assign req_rresp   = dram_rresp;
    assign req_rlast   = dram_rlast;

    // Outstanding count per requester: +1 on AR accept, -1 on last beat, both cancel out
    always_comb begin
        for (int i = 0; i < N; i++)
            outst_d[i] = outst_q[i] + CW'(ar_acc && gnt_q == SRC_W'(i))
                                    - CW'(rdone && rsrc == SRC_W'(i));
    end

    // State and payload registers, cleared immediately on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            rr_q      <= '0;
            gnt_q     <= '0;
            arid_q    <= '0;
            araddr_q  <= '0;
            arlen_q   <= '0;
            arsize_q  <= '0;
            arburst_q <= '0;
            for (int i = 0; i < N; i++) outst_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            gnt_q     <= gnt_d;
            arid_q    <= arid_d;
            araddr_q  <= araddr_d;
            arlen_q   <= arlen_d;
            arsize_q  <= arsize_d;
            arburst_q <= arburst_d;
            for (int i = 0; i < N; i++) outst_q[i] <= outst_d[i];
        end
    end

    rid_prefix_a: assert property (@(posedge clk) disable iff (rst) dram_rvalid |-> !rbad);
    outst_underflow_a: assert property (@(posedge clk) disable iff (rst) rdone |-> outst_q[rsrc] != '0);

endmodule
